// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the clock period meter: FSM state encoding
// and the default counter width, synchronizer depth and stall timeout.
package clk_meas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_STALL   = 2'd3
    } meas_state_e;

    localparam int DEF_CNT_WIDTH   = 28;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT     = 200000000;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level plus a history flop,
// producing the synchronized level and a single-cycle rising-edge strobe.
module sync_edge_det
    import clk_meas_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;
    logic                   hist_d;

    // shift the input through the chain; the last stage feeds the history flop
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // synchronizer and history registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~hist_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow square wave in system-clock cycles,
// reporting lock (repeatable measurements) and stall (no edges) conditions.
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 meas_valid,
    output logic                 rise_tick,
    output logic                 locked,
    output logic                 stalled
);

    localparam int                   PRIME_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [PRIME_W-1:0]   PRIME_DONE = PRIME_W'(SYNC_STAGES);
    localparam logic [PRIME_W-1:0]   PRIME_ONE  = PRIME_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C  = CNT_WIDTH'(TIMEOUT);

    logic s;
    logic rise;

    meas_state_e          state_q, state_d;
    logic [PRIME_W-1:0]   prime_q, prime_d;
    logic [CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_WIDTH-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] high_time_q, high_time_d;
    logic                 meas_valid_q, meas_valid_d;
    logic                 rise_tick_q, rise_tick_d;
    logic                 locked_q, locked_d;
    logic                 stalled_q, stalled_d;
    logic                 ref_valid_q, ref_valid_d;
    logic                 timeout_hit;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .sig_in(sig_in),
        .s     (s),
        .rise  (rise)
    );

    assign timeout_hit = (run_cnt_q == TIMEOUT_C);

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state; IDLE only trusts s once the synchronizer holds post-reset samples
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if ((prime_q == PRIME_DONE) && !s) state_d = ST_ARM;
                else                               state_d = ST_IDLE;
            end
            ST_ARM: begin
                if (rise) state_d = ST_MEASURE;
                else      state_d = ST_ARM;
            end
            ST_MEASURE: begin
                if (rise)             state_d = ST_MEASURE;
                else if (timeout_hit) state_d = ST_STALL;
                else                  state_d = ST_MEASURE;
            end
            ST_STALL: begin
                if (rise) state_d = ST_MEASURE;
                else      state_d = ST_STALL;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // counters, measurement capture, lock compare and stall flag
    always_comb begin
        prime_d      = ((state_q == ST_IDLE) && (prime_q != PRIME_DONE)) ? prime_q + PRIME_ONE : prime_q;
        run_cnt_d    = (run_cnt_q == CNT_MAX) ? run_cnt_q : run_cnt_q + CNT_ONE;
        high_cnt_d   = (s && (high_cnt_q != CNT_MAX)) ? high_cnt_q + CNT_ONE : high_cnt_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        rise_tick_d  = 1'b0;
        locked_d     = locked_q;
        stalled_d    = stalled_q;
        ref_valid_d  = ref_valid_q;
        case (state_q)
            ST_IDLE: begin
                rise_tick_d = 1'b0;
            end
            ST_ARM: begin
                if (rise) begin
                    run_cnt_d   = CNT_ONE;
                    high_cnt_d  = CNT_ONE;
                    rise_tick_d = 1'b1;
                end else begin
                    rise_tick_d = 1'b0;
                end
            end
            ST_MEASURE: begin
                if (rise) begin
                    run_cnt_d    = CNT_ONE;
                    high_cnt_d   = CNT_ONE;
                    rise_tick_d  = 1'b1;
                    meas_valid_d = 1'b1;
                    period_d     = run_cnt_q;
                    high_time_d  = high_cnt_q;
                    locked_d     = ref_valid_q && (run_cnt_q == period_q) && (high_cnt_q == high_time_q);
                    ref_valid_d  = 1'b1;
                end else if (timeout_hit) begin
                    stalled_d   = 1'b1;
                    locked_d    = 1'b0;
                    ref_valid_d = 1'b0;
                end else begin
                    stalled_d = 1'b0;
                end
            end
            ST_STALL: begin
                if (rise) begin
                    run_cnt_d   = CNT_ONE;
                    high_cnt_d  = CNT_ONE;
                    rise_tick_d = 1'b1;
                    stalled_d   = 1'b0;
                end else begin
                    stalled_d = 1'b1;
                end
            end
            default: begin
                rise_tick_d = 1'b0;
            end
        endcase
    end

    // datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            prime_q      <= '0;
            run_cnt_q    <= '0;
            high_cnt_q   <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            rise_tick_q  <= 1'b0;
            locked_q     <= 1'b0;
            stalled_q    <= 1'b0;
            ref_valid_q  <= 1'b0;
        end else begin
            prime_q      <= prime_d;
            run_cnt_q    <= run_cnt_d;
            high_cnt_q   <= high_cnt_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            rise_tick_q  <= rise_tick_d;
            locked_q     <= locked_d;
            stalled_q    <= stalled_d;
            ref_valid_q  <= ref_valid_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign rise_tick  = rise_tick_q;
    assign locked     = locked_q;
    assign stalled    = stalled_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: an edge-index model of the measured
// wave is checked against the DUT every cycle, plus literal checkpoints.
module tb_clk_period_meter;

    localparam int CW   = 16;
    localparam int SYNC = 2;
    localparam int TO   = 20;
    localparam int HMAX = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sig_in = 1'b0;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          meas_valid;
    logic          rise_tick;
    logic          locked;
    logic          stalled;

    clk_period_meter #(
        .CNT_WIDTH  (CW),
        .SYNC_STAGES(SYNC),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .rise_tick (rise_tick),
        .locked    (locked),
        .stalled   (stalled)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: sample history indexed by clock edge; the DUT acts at edge m on
    // the level sampled SYNC edges earlier. Period is the edge distance
    // between counted rises, high time the count of high levels in between.
    bit     samp [0:HMAX-1];
    bit     realv[0:HMAX-1];
    int     m = 0;
    int     mode = 0;          // 0 wait-low, 1 armed, 2 measuring, 3 stalled
    int     last_rise = 0;
    int     hsum = 0;
    int     ref_p = 0;
    int     ref_h = 0;
    bit     ref_ok = 1'b0;
    int     e_period = 0;
    int     e_high = 0;
    bit     e_mv = 1'b0;
    bit     e_rt = 1'b0;
    bit     e_lock = 1'b0;
    bit     e_stall = 1'b0;
    bit     started = 1'b0;

    always @(posedge clk) begin : model
        bit lv, lr, pv, rs;
        if (m < HMAX - 1) m++;
        samp[m]  = rst ? 1'b0 : sig_in;
        realv[m] = !rst;
        if (rst) begin
            mode = 0; ref_ok = 1'b0; e_period = 0; e_high = 0;
            e_mv = 1'b0; e_rt = 1'b0; e_lock = 1'b0; e_stall = 1'b0;
            started = 1'b1;
        end else begin
            lv = (m >= SYNC) ? samp[m-SYNC]  : 1'b0;
            lr = (m >= SYNC) ? realv[m-SYNC] : 1'b0;
            pv = (m >  SYNC) ? samp[m-SYNC-1] : 1'b0;
            rs = lv && !pv;
            e_mv = 1'b0;
            e_rt = 1'b0;
            case (mode)
                0: if (lr && !lv) mode = 1;
                1: if (rs) begin
                       e_rt = 1'b1; last_rise = m; hsum = 1; mode = 2;
                   end
                2: if (rs) begin
                       e_rt = 1'b1; e_mv = 1'b1;
                       e_lock = ref_ok && ((m - last_rise) == ref_p) && (hsum == ref_h);
                       ref_p = m - last_rise; ref_h = hsum; ref_ok = 1'b1;
                       e_period = ref_p; e_high = ref_h;
                       last_rise = m; hsum = 1;
                   end else if ((m - last_rise) == TO) begin
                       mode = 3; e_stall = 1'b1; e_lock = 1'b0; ref_ok = 1'b0;
                   end else begin
                       hsum += int'(lv);
                   end
                3: if (rs) begin
                       e_rt = 1'b1; e_stall = 1'b0; mode = 2; last_rise = m; hsum = 1;
                   end
                default: mode = 0;
            endcase
        end
    end

    int rt_dut = 0;
    int rt_mdl = 0;

    always @(negedge clk) begin
        if (started) begin
            cmp("period",     period,     e_period);
            cmp("high_time",  high_time,  e_high);
            cmp("meas_valid", meas_valid, e_mv);
            cmp("rise_tick",  rise_tick,  e_rt);
            cmp("locked",     locked,     e_lock);
            cmp("stalled",    stalled,    e_stall);
            if (rise_tick === 1'b1) rt_dut++;
            if (e_rt) rt_mdl++;
        end
    end

    task automatic lit(input string name, input logic [63:0] act, input logic [63:0] mdl, input logic [63:0] want);
        cmp({name, "_dut"},   act, want);
        cmp({name, "_model"}, mdl, want);
    endtask

    task automatic square(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            sig_in = 1'b1;
            repeat (hi) @(negedge clk);
            sig_in = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic lit_all_zero(input string tag);
        lit({tag, "_period"},  period,     e_period, 0);
        lit({tag, "_high"},    high_time,  e_high,   0);
        lit({tag, "_mv"},      meas_valid, e_mv,     0);
        lit({tag, "_rt"},      rise_tick,  e_rt,     0);
        lit({tag, "_locked"},  locked,     e_lock,   0);
        lit({tag, "_stalled"}, stalled,    e_stall,  0);
    endtask

    int rt_base_dut;
    int rt_base_mdl;

    initial begin
        rst = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        lit_all_zero("reset");
        rst = 1'b0;

        square(2, 2, 8);
        lit("sq22_period", period,    e_period, 4);
        lit("sq22_high",   high_time, e_high,   2);
        lit("sq22_locked", locked,    e_lock,   1);

        square(3, 9, 4);
        lit("sq39_period", period,    e_period, 12);
        lit("sq39_high",   high_time, e_high,   3);
        lit("sq39_locked", locked,    e_lock,   1);

        square(2, 2, 4);
        square(3, 3, 2);
        lit("chg_first_period", period, e_period, 6);
        lit("chg_first_locked", locked, e_lock,   0);
        square(3, 3, 3);
        lit("chg_relock_period", period, e_period, 6);
        lit("chg_relock_locked", locked, e_lock,   1);

        sig_in = 1'b0;
        repeat (30) @(negedge clk);
        lit("stall_flag",   stalled, e_stall,  1);
        lit("stall_locked", locked,  e_lock,   0);
        lit("stall_period", period,  e_period, 6);

        square(2, 2, 4);
        lit("resume_stalled", stalled, e_stall,  0);
        lit("resume_period",  period,  e_period, 4);
        lit("resume_locked",  locked,  e_lock,   1);

        sig_in = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rt_base_dut = rt_dut;
        rt_base_mdl = rt_mdl;
        repeat (10) @(negedge clk);
        lit("held_high_ticks", rt_dut - rt_base_dut, rt_mdl - rt_base_mdl, 0);
        square(2, 2, 5);
        lit("held_high_period", period, e_period, 4);
        lit("held_high_locked", locked, e_lock,   1);

        sig_in = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        lit_all_zero("midrst");
        rst = 1'b0;
        square(2, 2, 5);
        lit("after_rst_period", period, e_period, 4);
        lit("after_rst_locked", locked, e_lock,   1);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
